hue_div_ctrl: RTL

Sequencing controller for the hue divide step. Sits directly after `hue_stage0`: buffers its dividend/divisor/function triples in a small FIFO, runs one shared iterative restoring divider per entry, and maps the quotient plus sector into a 9-bit hue, 0..383, with 64 units per 60°. Results leave through a valid/ready handshake toward the threshold/mask logic.

---
 rtl/hue_pkg.sv | 41 ++++
 rtl/hue_fifo.sv | 53 +++++
 rtl/hue_div_ctrl.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/hue_pkg.sv
// hue_pkg: shared types and constants for the hue divide step.
//   hue_div_state_t : sequencing FSM states of hue_div_ctrl
//   HUE_BASE_*      : sector base hue (64 units per 60 degrees)
//   HUE_FULL        : one full turn of the hue circle
//   HUE_FRAC_BITS   : fractional quotient bits (q scaled by 64)
//   HUE_DIV_ITERS   : restoring-divider iterations per entry
//   FN_*            : sector / function codes from hue_stage0
package hue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DIV  = 2'd1,
        ST_ADJ  = 2'd2,
        ST_OUT  = 2'd3
    } hue_div_state_t;

    localparam int HUE_BASE_R    = 0;
    localparam int HUE_BASE_G    = 128;
    localparam int HUE_BASE_B    = 256;
    localparam int HUE_FULL      = 384;
    localparam int HUE_FRAC_BITS = 6;
    localparam int HUE_DIV_ITERS = 7;

    // FIFO payload: dividend(9) | divisor(8) | function(2)
    localparam int HUE_PAYLOAD_W = 19;

    localparam logic [1:0] FN_INVALID = 2'd0;
    localparam logic [1:0] FN_RED     = 2'd1;
    localparam logic [1:0] FN_GREEN   = 2'd2;
    localparam logic [1:0] FN_BLUE    = 2'd3;

    function automatic logic signed [9:0] hue_base(input logic [1:0] fn);
        case (fn)
            FN_RED:   return 10'(HUE_BASE_R);
            FN_GREEN: return 10'(HUE_BASE_G);
            FN_BLUE:  return 10'(HUE_BASE_B);
            default:  return '0;
        endcase
    endfunction

endpackage

// File: rtl/hue_fifo.sv
// hue_fifo: synchronous FIFO with full/empty flags.
//   i_clk, i_rst : clock, asynchronous active-high reset (empties the FIFO)
//   i_wr_en      : write i_wr_data at the clock edge
//   i_rd_en      : discard the head entry at the clock edge
//   o_rd_data    : head entry (valid while o_empty is low)
//   o_full       : DEPTH entries stored
//   o_empty      : no entries stored
// Writes and reads in the same cycle are both honoured, even when full:
// the slot being vacated is the one being written.
module hue_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 19
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_rd_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];

    assign o_empty   = (wr_ptr == rd_ptr);
    assign o_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign o_rd_data = mem[rd_ptr[AW-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (i_wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (i_rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define which
    // entries are meaningful, and an unreset array maps onto plain RAM.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) mem[wr_ptr[AW-1:0]] <= i_wr_data;
    end

endmodule

// File: rtl/hue_div_ctrl.sv
// hue_div_ctrl: buffers hue_stage0 triples, runs a shared 7-step restoring
// divider per entry and maps quotient + sector to a 9-bit hue (0..383).
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_dividend   : signed dividend (9b two's complement)
//   i_divisor    : unsigned divisor, max-min (0..255)
//   i_function   : sector code, 0 = invalid
//   i_valid      : triple present (no backpressure upstream)
//   o_hue        : hue result, held with o_valid until i_ready
//   o_valid      : result valid
//   i_ready      : downstream accepts o_hue on o_valid & i_ready
//   o_busy       : FIFO non-empty or FSM not idle
//   o_overflow   : sticky, set when a triple is dropped on a full FIFO
module hue_div_ctrl
    import hue_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [8:0] i_dividend,
    input  logic [8:0] i_divisor,
    input  logic [1:0] i_function,
    input  logic       i_valid,
    output logic [8:0] o_hue,
    output logic       o_valid,
    input  logic       i_ready,
    output logic       o_busy,
    output logic       o_overflow
);

    localparam logic [6:0] Q_SAT = 7'(1 << HUE_FRAC_BITS);

    // ---------------- input FIFO ----------------
    logic                     fifo_wr;
    logic                     fifo_pop;
    logic                     fifo_full;
    logic                     fifo_empty;
    logic [HUE_PAYLOAD_W-1:0] fifo_rdata;
    logic [7:0]               wr_divisor;

    // Divisor is 0..255 by construction; clamp rather than truncate if bit 8
    // ever arrives set.
    assign wr_divisor = i_divisor[8] ? 8'hFF : i_divisor[7:0];
    assign fifo_wr    = i_valid && (!fifo_full || fifo_pop);

    hue_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (HUE_PAYLOAD_W)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_wr_en   (fifo_wr),
        .i_wr_data ({i_dividend, wr_divisor, i_function}),
        .i_rd_en   (fifo_pop),
        .o_rd_data (fifo_rdata),
        .o_full    (fifo_full),
        .o_empty   (fifo_empty)
    );

    logic [8:0] head_dividend;
    logic [7:0] head_divisor;
    logic [1:0] head_func;
    logic [7:0] head_mag;

    assign head_dividend = fifo_rdata[18:10];
    assign head_divisor  = fifo_rdata[9:2];
    assign head_func     = fifo_rdata[1:0];
    // |dividend| in 8 bits; -256 never arrives.
    assign head_mag      = head_dividend[8] ? (~head_dividend[7:0] + 8'd1) : head_dividend[7:0];

    // ---------------- state and working registers ----------------
    hue_div_state_t state_q, state_d;
    logic [9:0]     rem_q, rem_d;
    logic [6:0]     quo_q, quo_d;
    logic [2:0]     iter_q, iter_d;
    logic [7:0]     dvs_q, dvs_d;
    logic [1:0]     func_q, func_d;
    logic           neg_q, neg_d;
    logic           sat_q, sat_d;
    logic           zero_q, zero_d;
    logic [8:0]     hue_q, hue_d;
    logic           valid_q, valid_d;
    logic           ovf_q, ovf_d;

    // Divider step: iteration 0 compares the unshifted magnitude (integer bit),
    // later iterations shift first (fractional bits).
    logic [9:0] rem_try;
    assign rem_try = (iter_q == 3'd0) ? rem_q : {rem_q[8:0], 1'b0};

    // Hue adjust: a magnitude larger than the divisor saturates q to 64.
    logic [6:0]        q_eff;
    logic signed [9:0] adj_sum;
    logic signed [9:0] adj_wrap;
    assign q_eff    = sat_q ? Q_SAT : quo_q;
    assign adj_sum  = neg_q ? hue_base(func_q) - $signed({3'b000, q_eff})
                            : hue_base(func_q) + $signed({3'b000, q_eff});
    assign adj_wrap = (adj_sum < 0) ? adj_sum + $signed(10'(HUE_FULL)) : adj_sum;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            iter_q  <= '0;
            dvs_q   <= '0;
            func_q  <= FN_INVALID;
            neg_q   <= 1'b0;
            sat_q   <= 1'b0;
            zero_q  <= 1'b0;
            hue_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            iter_q  <= iter_d;
            dvs_q   <= dvs_d;
            func_q  <= func_d;
            neg_q   <= neg_d;
            sat_q   <= sat_d;
            zero_q  <= zero_d;
            hue_q   <= hue_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        iter_d   = iter_q;
        dvs_d    = dvs_q;
        func_d   = func_q;
        neg_d    = neg_q;
        sat_d    = sat_q;
        zero_d   = zero_q;
        hue_d    = hue_q;
        valid_d  = valid_q;
        fifo_pop = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    neg_d    = head_dividend[8];
                    dvs_d    = head_divisor;
                    func_d   = head_func;
                    sat_d    = (head_mag > head_divisor);
                    zero_d   = (head_divisor == 8'd0) || (head_func == FN_INVALID);
                    rem_d    = {2'b00, head_mag};
                    quo_d    = '0;
                    iter_d   = '0;
                    state_d  = ((head_divisor == 8'd0) || (head_func == FN_INVALID)) ? ST_ADJ : ST_DIV;
                end
            end
            ST_DIV: begin
                if (rem_try >= {2'b00, dvs_q}) begin
                    rem_d = rem_try - {2'b00, dvs_q};
                    quo_d = {quo_q[5:0], 1'b1};
                end else begin
                    rem_d = rem_try;
                    quo_d = {quo_q[5:0], 1'b0};
                end
                iter_d = iter_q + 3'd1;
                if (iter_q == 3'(HUE_DIV_ITERS - 1)) state_d = ST_ADJ;
            end
            ST_ADJ: begin
                hue_d   = zero_q ? 9'd0 : adj_wrap[8:0];
                valid_d = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (i_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A triple is lost only when the FIFO is full and nothing leaves it.
    assign ovf_d = ovf_q || (i_valid && fifo_full && !fifo_pop);

    assign o_hue      = hue_q;
    assign o_valid    = valid_q;
    assign o_overflow = ovf_q;
    assign o_busy     = !fifo_empty || (state_q != ST_IDLE);

endmodule
